cpu_gen2: RTL and testbench

Parametrised second-generation accumulator CPU for the user area. It is a single-accumulator, 8-opcode machine with memory-reference, register-reference and I/O instruction classes, and it drives a single-port memory. Compared with the first generation it adds:
- configurable data and address widths;
- valid/ready handshakes on keyboard and display;
- interrupt flags with a vectored interrupt cycle;
- a halt instruction;
- single-cycle rotate through E;
- a non-tristate data-out bus.

---
 rtl/cpu_gen2_pkg.sv | 59 +++++
 rtl/cpu_gen2_opdec.sv | 20 ++
 rtl/cpu_gen2.sv | 338 +++++++++++++++++++++++++++++++++
 tb/tb_cpu_gen2.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_gen2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_gen2_pkg
// Description : Shared definitions for the cpu_gen2 accumulator CPU:
//               FSM state encoding, opcode values, register-reference and
//               I/O instruction bit positions.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_gen2_pkg;

    // Control FSM states. Encoding is explicit so waveforms stay stable.
    typedef enum logic [3:0] {
        S_F0   = 4'd0,
        S_F1   = 4'd1,
        S_DEC  = 4'd2,
        S_IND  = 4'd3,
        S_X0   = 4'd4,
        S_X1   = 4'd5,
        S_X2   = 4'd6,
        S_INT0 = 4'd7,
        S_INT1 = 4'd8,
        S_HALT = 4'd9
    } state_t;

    // Opcode field values (ir[DATA_W-2:DATA_W-4]).
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_IO  = 3'd7;

    // Register-reference bit positions within ir[11:0].
    localparam int RR_CLA = 11;
    localparam int RR_CLE = 10;
    localparam int RR_CMA = 9;
    localparam int RR_CME = 8;
    localparam int RR_CIR = 7;
    localparam int RR_CIL = 6;
    localparam int RR_INC = 5;
    localparam int RR_SPA = 4;
    localparam int RR_SNA = 3;
    localparam int RR_SZA = 2;
    localparam int RR_SZE = 1;
    localparam int RR_HLT = 0;

    // I/O instruction bit positions within ir[11:0].
    localparam int IO_INP = 11;
    localparam int IO_OUT = 10;
    localparam int IO_SKI = 9;
    localparam int IO_SKO = 8;
    localparam int IO_ION = 7;
    localparam int IO_IOF = 6;

endpackage
`default_nettype wire

// File: rtl/cpu_gen2_opdec.sv
`default_nettype none
// ============================================================================
// Module      : cpu_gen2_opdec
// Description : Combinational 3-to-8 one-hot opcode decoder.
// Ports       : i_opcode  [2:0]  opcode field of the instruction register
//               o_onehot  [7:0]  bit n set when i_opcode == n
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_gen2_opdec (
    input  logic [2:0] i_opcode,
    output logic [7:0] o_onehot
);

    always_comb begin
        o_onehot           = '0;
        o_onehot[i_opcode] = 1'b1;
    end

endmodule
`default_nettype wire

// File: rtl/cpu_gen2.sv
`default_nettype none
// ============================================================================
// Module      : cpu_gen2
// Description : Parametrised single-accumulator CPU with memory-reference,
//               register-reference and I/O instructions, vectored interrupt
//               cycle, halt, and valid/ready keyboard/display ports.
// Ports       : clk, rst         clock, synchronous active-high reset
//               addr       out   memory address (registered AR)
//               datain     in    asynchronous memory read data
//               dataout    out   memory write data (0 when not writing)
//               en, rdwr   out   access strobe, 1 = write
//               kbd_*            keyboard valid/ready input channel
//               disp_*           display valid/ready output channel
//               halted     out   HLT executed; left only by rst
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_gen2 #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int IO_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] datain,
    output logic [DATA_W-1:0] dataout,
    output logic              en,
    output logic              rdwr,
    input  logic [IO_W-1:0]   kbd_data,
    input  logic              kbd_valid,
    output logic              kbd_ready,
    output logic [IO_W-1:0]   disp_data,
    output logic              disp_valid,
    input  logic              disp_ready,
    output logic              halted
);

    import cpu_gen2_pkg::*;

    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);
    localparam logic [DATA_W-1:0] c_data_one = DATA_W'(1);

    // ------------------------------------------------------------------
    // Architectural registers and their next-state values
    // ------------------------------------------------------------------
    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_pc,    w_pc_nxt;
    logic [ADDR_W-1:0]   r_ar,    w_ar_nxt;
    logic [DATA_W-1:0]   r_ir,    w_ir_nxt;
    logic [DATA_W-1:0]   r_ac,    w_ac_nxt;
    logic [DATA_W-1:0]   r_dr,    w_dr_nxt;
    logic                r_e,     w_e_nxt;
    logic                r_ien,   w_ien_nxt;
    logic                r_fgi,   w_fgi_nxt;
    logic                r_fgo,   w_fgo_nxt;
    logic [IO_W-1:0]     r_kbuf,  w_kbuf_nxt;
    logic [IO_W-1:0]     r_disp,  w_disp_nxt;

    // ------------------------------------------------------------------
    // Instruction field decode
    // ------------------------------------------------------------------
    logic                w_ibit;
    logic [2:0]          w_opcode;
    logic [7:0]          w_op_oh;
    logic [ADDR_W-1:0]   w_field;
    logic [11:0]         w_bits;
    logic                w_is_rr;
    logic                w_is_io;
    logic                w_mri_read;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_pc_ext;
    logic                w_rr_skip;
    logic                w_io_skip;
    logic                w_kbd_fire;
    logic                w_disp_fire;

    assign w_ibit   = r_ir[DATA_W-1];
    assign w_opcode = r_ir[DATA_W-2:DATA_W-4];
    assign w_field  = r_ir[ADDR_W-1:0];
    assign w_bits   = r_ir[11:0];

    cpu_gen2_opdec u_opdec (
        .i_opcode (w_opcode),
        .o_onehot (w_op_oh)
    );

    assign w_is_rr    = w_op_oh[OP_IO] & ~w_ibit;
    assign w_is_io    = w_op_oh[OP_IO] &  w_ibit;
    // Memory-reference ops whose X0 cycle loads DR from memory.
    assign w_mri_read = w_op_oh[OP_AND] | w_op_oh[OP_ADD] |
                        w_op_oh[OP_LDA] | w_op_oh[OP_ISZ];

    // One bit wider than the datapath so the carry lands in E.
    assign w_sum    = {1'b0, r_ac} + {1'b0, r_dr};
    assign w_pc_ext = {{(DATA_W-ADDR_W){1'b0}}, r_pc};

    // Skip conditions all look at pre-instruction values.
    assign w_rr_skip = (w_bits[RR_SPA] & ~r_ac[DATA_W-1]) |
                       (w_bits[RR_SNA] &  r_ac[DATA_W-1]) |
                       (w_bits[RR_SZA] & (r_ac == '0))    |
                       (w_bits[RR_SZE] & ~r_e);
    assign w_io_skip = (w_bits[IO_SKI] & r_fgi) |
                       (w_bits[IO_SKO] & r_fgo);

    // Ready/valid are straight inversions of the device flags.
    assign kbd_ready   = ~r_fgi;
    assign disp_valid  = ~r_fgo;
    assign w_kbd_fire  = kbd_valid & ~r_fgi;
    assign w_disp_fire = disp_ready & ~r_fgo;

    assign addr      = r_ar;
    assign disp_data = r_disp;
    assign halted    = (r_state == S_HALT);

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ar_nxt    = r_ar;
        w_ir_nxt    = r_ir;
        w_ac_nxt    = r_ac;
        w_dr_nxt    = r_dr;
        w_e_nxt     = r_e;
        w_ien_nxt   = r_ien;
        w_fgi_nxt   = r_fgi;
        w_fgo_nxt   = r_fgo;
        w_kbuf_nxt  = r_kbuf;
        w_disp_nxt  = r_disp;

        case (r_state)
            S_F0: begin
                // Interrupts are only taken between instructions.
                if (r_ien && (r_fgi || r_fgo)) begin
                    w_state_nxt = S_INT0;
                end else begin
                    w_ar_nxt    = r_pc;
                    w_state_nxt = S_F1;
                end
            end

            S_F1: begin
                w_ir_nxt    = datain;
                w_pc_nxt    = r_pc + c_addr_one;
                w_state_nxt = S_DEC;
            end

            S_DEC: begin
                w_ar_nxt = w_field;
                if (!w_op_oh[OP_IO] && w_ibit) begin
                    w_state_nxt = S_IND;
                end else begin
                    w_state_nxt = S_X0;
                end
            end

            S_IND: begin
                w_ar_nxt    = datain[ADDR_W-1:0];
                w_state_nxt = S_X0;
            end

            S_X0: begin
                w_state_nxt = S_F0;
                if (w_is_rr) begin
                    // Later assignments take precedence: ordered from the
                    // lowest-numbered bit to the highest.
                    if (w_bits[RR_INC]) w_ac_nxt = r_ac + c_data_one;
                    if (w_bits[RR_CIL]) begin
                        w_ac_nxt = {r_ac[DATA_W-2:0], r_e};
                        w_e_nxt  = r_ac[DATA_W-1];
                    end
                    if (w_bits[RR_CIR]) begin
                        w_ac_nxt = {r_e, r_ac[DATA_W-1:1]};
                        w_e_nxt  = r_ac[0];
                    end
                    if (w_bits[RR_CME]) w_e_nxt  = ~r_e;
                    if (w_bits[RR_CMA]) w_ac_nxt = ~r_ac;
                    if (w_bits[RR_CLE]) w_e_nxt  = 1'b0;
                    if (w_bits[RR_CLA]) w_ac_nxt = '0;
                    if (w_rr_skip)      w_pc_nxt = r_pc + c_addr_one;
                    if (w_bits[RR_HLT]) w_state_nxt = S_HALT;
                end else if (w_is_io) begin
                    if (w_bits[IO_INP]) begin
                        w_ac_nxt[IO_W-1:0] = r_kbuf;
                        w_fgi_nxt          = 1'b0;
                    end
                    if (w_bits[IO_OUT]) begin
                        w_disp_nxt = r_ac[IO_W-1:0];
                        w_fgo_nxt  = 1'b0;
                    end
                    if (w_io_skip)      w_pc_nxt  = r_pc + c_addr_one;
                    if (w_bits[IO_ION]) w_ien_nxt = 1'b1;
                    if (w_bits[IO_IOF]) w_ien_nxt = 1'b0;
                end else begin
                    if (w_mri_read) begin
                        w_dr_nxt    = datain;
                        w_state_nxt = S_X1;
                    end
                    if (w_op_oh[OP_BUN]) w_pc_nxt = r_ar;
                    if (w_op_oh[OP_BSA]) begin
                        w_ar_nxt    = r_ar + c_addr_one;
                        w_state_nxt = S_X1;
                    end
                end
            end

            S_X1: begin
                w_state_nxt = S_F0;
                if (w_op_oh[OP_AND]) w_ac_nxt = r_ac & r_dr;
                if (w_op_oh[OP_ADD]) {w_e_nxt, w_ac_nxt} = w_sum;
                if (w_op_oh[OP_LDA]) w_ac_nxt = r_dr;
                if (w_op_oh[OP_BSA]) w_pc_nxt = r_ar;
                if (w_op_oh[OP_ISZ]) begin
                    w_dr_nxt    = r_dr + c_data_one;
                    w_state_nxt = S_X2;
                end
            end

            S_X2: begin
                // DR already holds the incremented value being written.
                if (r_dr == '0) w_pc_nxt = r_pc + c_addr_one;
                w_state_nxt = S_F0;
            end

            S_INT0: begin
                w_ar_nxt    = '0;
                w_state_nxt = S_INT1;
            end

            S_INT1: begin
                w_pc_nxt    = c_addr_one;
                w_ien_nxt   = 1'b0;
                w_state_nxt = S_F0;
            end

            S_HALT: begin
                w_state_nxt = S_HALT;
            end

            default: begin
                w_state_nxt = S_F0;
            end
        endcase

        // Device-side handshakes. These cannot collide with the INP/OUT
        // clears above since ready/valid are low whenever a clear is legal.
        if (w_kbd_fire) begin
            w_kbuf_nxt = kbd_data;
            w_fgi_nxt  = 1'b1;
        end
        if (w_disp_fire) begin
            w_fgo_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Memory strobes; suppressed while rst is high so an interrupted
    // instruction never commits a partial write.
    // ------------------------------------------------------------------
    always_comb begin
        en      = 1'b0;
        rdwr    = 1'b0;
        dataout = '0;
        if (!rst) begin
            case (r_state)
                S_F1, S_IND: begin
                    en = 1'b1;
                end
                S_X0: begin
                    if (!w_op_oh[OP_IO]) begin
                        if (w_mri_read) begin
                            en = 1'b1;
                        end
                        if (w_op_oh[OP_STA]) begin
                            en      = 1'b1;
                            rdwr    = 1'b1;
                            dataout = r_ac;
                        end
                        if (w_op_oh[OP_BSA]) begin
                            en      = 1'b1;
                            rdwr    = 1'b1;
                            dataout = w_pc_ext;
                        end
                    end
                end
                S_X2: begin
                    en      = 1'b1;
                    rdwr    = 1'b1;
                    dataout = r_dr;
                end
                S_INT1: begin
                    en      = 1'b1;
                    rdwr    = 1'b1;
                    dataout = w_pc_ext;
                end
                default: begin
                    en = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and register update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_F0;
            r_pc    <= '0;
            r_ar    <= '0;
            r_ir    <= '0;
            r_ac    <= '0;
            r_dr    <= '0;
            r_e     <= 1'b0;
            r_ien   <= 1'b0;
            r_fgi   <= 1'b0;
            r_fgo   <= 1'b1;
            r_kbuf  <= '0;
            r_disp  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ar    <= w_ar_nxt;
            r_ir    <= w_ir_nxt;
            r_ac    <= w_ac_nxt;
            r_dr    <= w_dr_nxt;
            r_e     <= w_e_nxt;
            r_ien   <= w_ien_nxt;
            r_fgi   <= w_fgi_nxt;
            r_fgo   <= w_fgo_nxt;
            r_kbuf  <= w_kbuf_nxt;
            r_disp  <= w_disp_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_gen2.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_gen2
// Description : Self-checking bench for cpu_gen2. Two instances (16/12 and
//               24/16 widths) each drive a behavioural memory; every memory
//               write is matched against a queue of expected writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_gen2;

    logic        clk;
    logic        rst;
    logic        rst2;

    // Instance 1: default widths
    logic [11:0] addr;
    logic [15:0] datain;
    logic [15:0] dataout;
    logic        en;
    logic        rdwr;
    logic [7:0]  kbd_data;
    logic        kbd_valid;
    logic        kbd_ready;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        disp_ready;
    logic        halted;

    // Instance 2: DATA_W=24, ADDR_W=16
    logic [15:0] addr2;
    logic [23:0] datain2;
    logic [23:0] dataout2;
    logic        en2;
    logic        rdwr2;
    logic [7:0]  kbd_data2;
    logic        kbd_valid2;
    logic        kbd_ready2;
    logic [7:0]  disp_data2;
    logic        disp_valid2;
    logic        disp_ready2;
    logic        halted2;

    logic [15:0] mem1 [0:4095];
    logic [23:0] mem2 [0:65535];
    logic        ld1_en;
    logic [11:0] ld1_a;
    logic [15:0] ld1_d;
    logic        ld2_en;
    logic [15:0] ld2_a;
    logic [23:0] ld2_d;

    logic [63:0] sb1 [$];
    logic [63:0] sb2 [$];
    int          n_cmp;
    int          n_bad;

    cpu_gen2 dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .datain     (datain),
        .dataout    (dataout),
        .en         (en),
        .rdwr       (rdwr),
        .kbd_data   (kbd_data),
        .kbd_valid  (kbd_valid),
        .kbd_ready  (kbd_ready),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .halted     (halted)
    );

    cpu_gen2 #(.DATA_W(24), .ADDR_W(16), .IO_W(8)) dut2 (
        .clk        (clk),
        .rst        (rst2),
        .addr       (addr2),
        .datain     (datain2),
        .dataout    (dataout2),
        .en         (en2),
        .rdwr       (rdwr2),
        .kbd_data   (kbd_data2),
        .kbd_valid  (kbd_valid2),
        .kbd_ready  (kbd_ready2),
        .disp_data  (disp_data2),
        .disp_valid (disp_valid2),
        .disp_ready (disp_ready2),
        .halted     (halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read, write-on-edge memories. The bench loads programs
    // through the ld ports so each array has a single writing process.
    assign datain  = mem1[addr];
    assign datain2 = mem2[addr2];

    always @(posedge clk) begin
        if (ld1_en)            mem1[ld1_a] <= ld1_d;
        else if (en && rdwr)   mem1[addr]  <= dataout;
        if (ld2_en)            mem2[ld2_a] <= ld2_d;
        else if (en2 && rdwr2) mem2[addr2] <= dataout2;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic put1(input int a, input int d);
        ld1_a  = 12'(a);
        ld1_d  = 16'(d);
        ld1_en = 1'b1;
        @(negedge clk);
        ld1_en = 1'b0;
    endtask

    task automatic put2(input int a, input int d);
        ld2_a  = 16'(a);
        ld2_d  = 24'(d);
        ld2_en = 1'b1;
        @(negedge clk);
        ld2_en = 1'b0;
    endtask

    task automatic exp1(input int a, input int d);
        sb1.push_back({a, d});
    endtask

    task automatic exp2(input int a, input int d);
        sb2.push_back({a, d});
    endtask

    task automatic mon1();
        forever begin
            @(negedge clk);
            if (en && rdwr) begin
                if (sb1.size() == 0) begin
                    check("wr1_unexpected", {1'b1, 31'(addr), 32'(dataout)}, 64'd0);
                end else begin
                    check("wr1", {32'(addr), 32'(dataout)}, sb1.pop_front());
                end
            end
        end
    endtask

    task automatic mon2();
        forever begin
            @(negedge clk);
            if (en2 && rdwr2) begin
                if (sb2.size() == 0) begin
                    check("wr2_unexpected", {1'b1, 31'(addr2), 32'(dataout2)}, 64'd0);
                end else begin
                    check("wr2", {32'(addr2), 32'(dataout2)}, sb2.pop_front());
                end
            end
        end
    endtask

    task automatic restart1();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wait_halt1(input int budget, input string tag);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(halted), 64'd1);
    endtask

    task automatic wait_halt2(input int budget, input string tag);
        int n = 0;
        while (!halted2 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(halted2), 64'd1);
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        rst2        = 1'b1;
        kbd_data    = 8'h00;
        kbd_valid   = 1'b0;
        disp_ready  = 1'b0;
        kbd_data2   = 8'h00;
        kbd_valid2  = 1'b0;
        disp_ready2 = 1'b0;
        ld1_en      = 1'b0;
        ld1_a       = '0;
        ld1_d       = '0;
        ld2_en      = 1'b0;
        ld2_a       = '0;
        ld2_d       = '0;
        fork
            mon1();
            mon2();
        join_none
        repeat (2) @(negedge clk);

        // ---------------- Reset outputs and LDA fetch timing ----------------
        check("rst_en",         64'(en),         64'd0);
        check("rst_rdwr",       64'(rdwr),       64'd0);
        check("rst_dataout",    64'(dataout),    64'd0);
        check("rst_kbd_ready",  64'(kbd_ready),  64'd1);
        check("rst_disp_valid", 64'(disp_valid), 64'd0);
        check("rst_disp_data",  64'(disp_data),  64'd0);
        check("rst_halted",     64'(halted),     64'd0);
        check("rst_addr",       64'(addr),       64'd0);
        check("rst2_kbd_ready", 64'(kbd_ready2), 64'd1);
        check("rst2_disp",      64'({disp_valid2, disp_data2}), 64'd0);
        put1(12'h000, 16'h2005);          // LDA 0x005
        put1(12'h001, 16'h3030);          // STA 0x030
        put1(12'h002, 16'h7001);          // HLT
        put1(12'h005, 16'h1234);
        exp1(12'h030, 16'h1234);
        rst = 1'b0;
        repeat (3) @(negedge clk);        // now in X0
        check("lda_x0_addr", 64'(addr), 64'h005);
        check("lda_x0_strb", 64'({en, rdwr}), 64'b10);
        repeat (2) @(negedge clk);        // back in F0 after 5 cycles
        check("lda_f0_en", 64'(en), 64'd0);
        @(negedge clk);                   // F1 of next instruction: AR=PC
        check("lda_next_pc", 64'(addr), 64'h001);
        wait_halt1(100, "t1_halt");

        // ---------------- ADD with carry, then CIL ----------------
        restart1();
        put1(12'h000, 16'h2040);          // LDA 0x040
        put1(12'h001, 16'h1041);          // ADD 0x041
        put1(12'h002, 16'h3050);          // STA 0x050
        put1(12'h003, 16'h7040);          // CIL
        put1(12'h004, 16'h3051);          // STA 0x051
        put1(12'h005, 16'h7040);          // CIL
        put1(12'h006, 16'h3052);          // STA 0x052
        put1(12'h007, 16'h7001);          // HLT
        put1(12'h040, 16'hFFFF);
        put1(12'h041, 16'h0001);
        exp1(12'h050, 16'h0000);
        exp1(12'h051, 16'h0001);          // E=1 rotated in
        exp1(12'h052, 16'h0002);          // E was 0 after first CIL
        rst = 1'b0;
        wait_halt1(200, "t2_halt");

        // ---------------- Indirect LDA, ISZ skip, BSA ----------------
        restart1();
        put1(12'h000, 16'hA010);          // LDA I 0x010
        put1(12'h001, 16'h3060);          // STA 0x060
        put1(12'h002, 16'h6070);          // ISZ 0x070
        put1(12'h003, 16'h3061);          // STA 0x061 (skipped)
        put1(12'h004, 16'h5100);          // BSA 0x100
        put1(12'h010, 16'h0020);
        put1(12'h020, 16'hBEEF);
        put1(12'h070, 16'hFFFF);
        put1(12'h101, 16'h3063);          // STA 0x063
        put1(12'h102, 16'h7001);          // HLT
        exp1(12'h060, 16'hBEEF);
        exp1(12'h070, 16'h0000);
        exp1(12'h100, 16'h0005);          // return address
        exp1(12'h063, 16'hBEEF);
        rst = 1'b0;
        repeat (4) @(negedge clk);        // F0 F1 DEC IND -> X0
        check("ind_x0_addr", 64'(addr), 64'h020);
        check("ind_x0_strb", 64'({en, rdwr}), 64'b10);
        wait_halt1(200, "t3_halt");

        // ---------------- Keyboard / display handshake ----------------
        restart1();
        put1(12'h000, 16'hF200);          // SKI
        put1(12'h001, 16'h3080);          // STA 0x080 (skipped)
        put1(12'h002, 16'hF800);          // INP
        put1(12'h003, 16'h3081);          // STA 0x081
        put1(12'h004, 16'hF400);          // OUT
        put1(12'h005, 16'h7001);          // HLT
        exp1(12'h081, 16'h0041);
        kbd_data  = 8'h41;
        kbd_valid = 1'b1;
        rst       = 1'b0;
        @(negedge clk);
        check("kbd_ready_drop", 64'(kbd_ready), 64'd0);
        kbd_valid = 1'b0;
        wait_halt1(200, "t4_halt");
        check("kbd_ready_back", 64'(kbd_ready),  64'd1);
        check("disp_valid_set", 64'(disp_valid), 64'd1);
        check("disp_data",      64'(disp_data),  64'h41);
        repeat (3) @(negedge clk);
        check("disp_hold", 64'(disp_valid), 64'd1);
        disp_ready = 1'b1;
        @(negedge clk);
        disp_ready = 1'b0;
        check("disp_accept", 64'(disp_valid), 64'd0);

        // ---------------- Interrupt entry, then halt freeze ----------------
        restart1();
        put1(12'h000, 16'hF080);          // ION (FGO=1 from reset)
        put1(12'h001, 16'h3090);          // STA 0x090
        put1(12'h002, 16'h7001);          // HLT
        exp1(12'h000, 16'h0001);          // interrupt saves PC=1 to mem[0]
        exp1(12'h090, 16'h0000);          // IEN cleared: no second interrupt
        rst = 1'b0;
        wait_halt1(200, "t5_halt");
        repeat (10) @(negedge clk);
        check("halt_stays",  64'(halted), 64'd1);
        check("halt_addr",   64'(addr),   64'h001);
        check("halt_no_mem", 64'(en),     64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("halt_cleared", 64'(halted), 64'd0);

        // ---------------- Wide instance: LDA / ADD / CIL ----------------
        put2(16'h0000, 24'h201005);       // LDA 0x1005
        put2(16'h0001, 24'h302002);       // STA 0x2002
        put2(16'h0002, 24'h101006);       // ADD 0x1006
        put2(16'h0003, 24'h302000);       // STA 0x2000
        put2(16'h0004, 24'h700040);       // CIL
        put2(16'h0005, 24'h302001);       // STA 0x2001
        put2(16'h0006, 24'h700001);       // HLT
        put2(16'h1005, 24'hFFFFFF);
        put2(16'h1006, 24'h000001);
        exp2(16'h2002, 24'hFFFFFF);
        exp2(16'h2000, 24'h000000);
        exp2(16'h2001, 24'h000001);
        rst2 = 1'b0;
        wait_halt2(200, "w_halt");

        repeat (3) @(negedge clk);
        check("sb1_drained", 64'(sb1.size()), 64'd0);
        check("sb2_drained", 64'(sb2.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
